// File: rtl/sd_cmd_responder.sv
// SD CMD-line device-side responder: receives 48-bit host commands, checks CRC7,
// and transmits a 48-bit response after the NCR gap when the user supplies one.
module sd_cmd_responder #(
  parameter int unsigned NCR_CYCLES   = 2,
  parameter int unsigned RESP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sdio_clk,
  input  logic        sdio_cmd_in,
  output logic        sdio_cmd_out,
  output logic        sdio_cmd_oe,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        cmd_crc_err,
  output logic        resp_ready,
  input  logic        resp_valid,
  input  logic        resp_drop,
  input  logic        resp_no_crc,
  input  logic [5:0]  resp_index,
  input  logic [31:0] resp_arg,
  output logic        resp_timeout,
  output logic        busy
);

  localparam int unsigned TOW = $clog2(RESP_TIMEOUT + 1);
  localparam int unsigned CW  = (TOW > 7) ? TOW : 7;
  localparam logic [CW-1:0] C_MAX   = '1;
  localparam logic [CW-1:0] TO_LAST = CW'(RESP_TIMEOUT - 1);
  localparam logic [CW-1:0] NCR_TH  = CW'(NCR_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_RX, S_WAIT_RESP, S_NCR, S_TX, S_DONE} state_t;
  state_t r_state, w_next;

  logic [1:0]    r_clk_sync, r_cmd_sync;
  logic          r_clk_prev;
  logic [46:0]   r_rx;
  logic [5:0]    r_bcnt;
  logic [CW-1:0] r_ecnt;
  logic [47:0]   r_tx;
  logic          r_oe, r_out;
  logic          w_rise, w_fall, w_cmd;
  logic [47:0]   w_frame;
  logic          w_rx_last, w_rx_err, w_xfer, w_tmo;
  logic [6:0]    w_rsp_crc;

  function automatic logic [6:0] f_crc7(input logic [39:0] d);
    logic [6:0]  c;
    logic [39:0] s;
    logic        fb;
    c = '0;
    s = d;
    for (int unsigned i = 0; i < 40; i++) begin
      fb = s[39] ^ c[6];
      c  = {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
      s  = {s[38:0], 1'b0};
    end
    return c;
  endfunction

  assign w_rise    = r_clk_sync[1] & ~r_clk_prev;
  assign w_fall    = ~r_clk_sync[1] & r_clk_prev;
  assign w_cmd     = r_cmd_sync[1];
  assign w_frame   = {r_rx, w_cmd};
  assign w_rx_last = (r_state == S_RX) && w_rise && (r_bcnt == '0);
  assign w_rx_err  = (f_crc7(w_frame[47:8]) != w_frame[7:1]) | ~w_frame[46] | ~w_frame[0];
  assign w_xfer    = (r_state == S_WAIT_RESP) && resp_valid;
  assign w_tmo     = (r_state == S_WAIT_RESP) && !resp_valid && w_rise && (r_ecnt == TO_LAST);
  assign w_rsp_crc = resp_no_crc ? 7'h7F : f_crc7({2'b00, resp_index, resp_arg});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (w_rise && !w_cmd) w_next = S_RX;
      S_RX:        if (w_rx_last) w_next = w_rx_err ? S_IDLE : S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (w_xfer)     w_next = resp_drop ? S_IDLE : S_NCR;
        else if (w_tmo) w_next = S_IDLE;
      end
      S_NCR:       if (r_ecnt >= NCR_TH) w_next = S_TX;
      S_TX:        if (w_fall && (r_bcnt == '0)) w_next = S_DONE;
      S_DONE:      if (w_fall) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    resp_ready   = (r_state == S_WAIT_RESP);
    busy         = (r_state != S_IDLE);
    sdio_cmd_oe  = r_oe;
    sdio_cmd_out = r_out;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_sync   <= '0;
      r_cmd_sync   <= '1;
      r_clk_prev   <= 1'b0;
      r_rx         <= '0;
      r_bcnt       <= '0;
      r_ecnt       <= '0;
      r_tx         <= '0;
      r_oe         <= 1'b0;
      r_out        <= 1'b1;
      cmd_valid    <= 1'b0;
      cmd_index    <= '0;
      cmd_arg      <= '0;
      cmd_crc_err  <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      r_clk_sync   <= {r_clk_sync[0], sdio_clk};
      r_cmd_sync   <= {r_cmd_sync[0], sdio_cmd_in};
      r_clk_prev   <= r_clk_sync[1];
      cmd_valid    <= w_rx_last;
      resp_timeout <= w_tmo;
      if (w_rise && (r_state == S_IDLE || r_state == S_RX))
        r_rx <= {r_rx[45:0], w_cmd};
      if (r_state == S_IDLE)
        r_bcnt <= 6'd46;
      else if (r_state == S_RX && w_rise && r_bcnt != '0)
        r_bcnt <= r_bcnt - 6'd1;
      // One edge counter serves both NCR gap and response timeout, both counted from the end bit.
      if (w_rx_last) begin
        cmd_index   <= w_frame[45:40];
        cmd_arg     <= w_frame[39:8];
        cmd_crc_err <= w_rx_err;
        r_ecnt      <= '0;
      end else if (w_rise && (r_state == S_WAIT_RESP || r_state == S_NCR) && r_ecnt != C_MAX) begin
        r_ecnt <= r_ecnt + 1'b1;
      end
      if (w_xfer && !resp_drop) begin
        r_tx   <= {2'b00, resp_index, resp_arg, w_rsp_crc, 1'b1};
        r_bcnt <= 6'd47;
      end
      if (r_state == S_TX && w_fall) begin
        r_oe  <= 1'b1;
        r_out <= r_tx[47];
        r_tx  <= {r_tx[46:0], 1'b0};
        if (r_bcnt != '0) r_bcnt <= r_bcnt - 6'd1;
      end
      if (r_state == S_DONE && w_fall) begin
        r_oe  <= 1'b0;
        r_out <= 1'b1;
      end
    end
  end

endmodule
